// File: rtl/mult_share_pkg.sv
// Shared types and default widths for the multiplier sharing arbiter.
package mult_share_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RESP} msa_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_W     = 2;
  localparam int DEF_B_W     = 2;
  localparam int DEF_OUT_W   = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, modulo NUM_REQ.
// Zero latency; no flow control of its own.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = ID_W'((int'(ptr) + off) % NUM_REQ);
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/multiplier_share_arbiter.sv
// Round-robin sharing of one combinational multiplier; accept->rsp_valid after two edges.
// One op in flight; rsp_ready low holds the response and blocks all new accepts.
module multiplier_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [A_W-1:0]         mul_a,
  output logic [B_W-1:0]         mul_b,
  input  logic [OUT_W-1:0]       mul_p,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [OUT_W-1:0]       rsp_data
);

  msa_state_t          state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id_q;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_vld;
  logic                accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Gated by rst_n so req_ready drops the instant reset asserts, not at the next edge.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign accept    = (state == IDLE) && grant_vld;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      id_q      <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mul_a  <= req_a[grant_idx*A_W +: A_W];
            mul_b  <= req_b[grant_idx*B_W +: B_W];
            id_q   <= grant_idx;
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
          end
        end
        CALC: begin
          rsp_data  <= mul_p;
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_share_arbiter.sv
// Randomized + directed bench for multiplier_share_arbiter with a transaction-level scoreboard.
module tb_multiplier_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int A_W     = 2;
  localparam int B_W     = 2;
  localparam int OUT_W   = 5;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [A_W-1:0]         mul_a;
  logic [B_W-1:0]         mul_b;
  logic [OUT_W-1:0]       mul_p;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [OUT_W-1:0]       rsp_data;

  always #5 clk = ~clk;

  assign mul_p = OUT_W'(mul_a) * OUT_W'(mul_b);

  multiplier_share_arbiter #(
    .NUM_REQ (NUM_REQ), .A_W (A_W), .B_W (B_W), .OUT_W (OUT_W), .ID_W (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  typedef struct { int id; int data; int due; } exp_t;
  exp_t sb[$];
  int   act_ids[$];
  int   act_data[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model: one transaction at a time, round-robin pointer kept as an integer.
  bit m_busy = 1'b0;
  int m_ptr = 0, m_due = 0, m_last_a = 0, m_last_b = 0;
  int g, ea, eb, k;
  int exp_rdy;
  bit exp_valid;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("mul_a_hold", int'(mul_a), m_last_a);
      chk("mul_b_hold", int'(mul_b), m_last_b);
      if (!m_busy) begin
        g = -1;
        for (int off = 0; off < NUM_REQ; off++) begin
          k = (m_ptr + off) % NUM_REQ;
          if (g < 0 && req_valid[k]) g = k;
        end
        exp_rdy = (g >= 0) ? (1 << g) : 0;
        chk("req_ready", int'(req_ready), exp_rdy);
        if (g >= 0) begin
          ea = int'(req_a[g*A_W +: A_W]);
          eb = int'(req_b[g*B_W +: B_W]);
          sb.push_back('{g, ea * eb, cyc + 2});
          m_ptr    = (g + 1) % NUM_REQ;
          m_busy   = 1'b1;
          m_due    = cyc + 2;
          m_last_a = ea;
          m_last_b = eb;
        end
      end else begin
        chk("req_ready_busy", int'(req_ready), 0);
        if (cyc >= m_due && rsp_ready) m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      exp_valid = (sb.size() > 0) && (sb[0].due <= cyc);
      chk("rsp_valid", int'(rsp_valid), int'(exp_valid));
      if (rsp_valid && sb.size() > 0) begin
        chk("rsp_id", int'(rsp_id), sb[0].id);
        chk("rsp_data", int'(rsp_data), sb[0].data);
        if (rsp_ready) begin
          act_ids.push_back(int'(rsp_id));
          act_data.push_back(int'(rsp_data));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*A_W +: A_W] = A_W'(a);
    req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  // One clock: requesters drop (or refill) once accepted; rnd also churns pending ones.
  task automatic cycle(input bit refill, input bit rnd);
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rnd) begin
        if (acc[i] || $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_op(i, $urandom_range(0, 3), $urandom_range(0, 3));
        end
      end else if (acc[i]) begin
        if (refill) set_op(i, $urandom_range(0, 3), $urandom_range(0, 3));
        else        req_valid[i] = 1'b0;
      end
    end
    if (rnd) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    chk({nm, "_seen"}, int'(rsp_valid), 1);
  endtask

  task automatic wait_rsps(input string nm, input int cnt, input bit refill);
    int n = 0;
    while (act_ids.size() < cnt && n < 40) begin
      cycle(refill, 1'b0);
      n++;
    end
    chk({nm, "_count"}, act_ids.size(), cnt);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((sb.size() > 0 || m_busy) && n < 40) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic check_outputs_zero(input string nm);
    chk({nm, "_req_ready"}, int'(req_ready), 0);
    chk({nm, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({nm, "_rsp_id"},    int'(rsp_id), 0);
    chk({nm, "_rsp_data"},  int'(rsp_data), 0);
    chk({nm, "_mul_a"},     int'(mul_a), 0);
    chk({nm, "_mul_b"},     int'(mul_b), 0);
  endtask

  initial begin
    int n, cid, cdat;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    check_outputs_zero("reset");
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;

    // All four requesters continuously valid from a freshly reset pointer.
    for (int i = 0; i < NUM_REQ; i++) set_op(i, $urandom_range(0, 3), $urandom_range(0, 3));
    act_ids.delete(); act_data.delete();
    req_valid = '1;
    wait_rsps("rr4", 5, 1'b1);
    req_valid = '0;
    for (int i = 0; i < 5 && i < act_ids.size(); i++) chk("rr4_order", act_ids[i], i % NUM_REQ);
    drain();

    // Lone requester 2 with the largest operands.
    set_op(2, 3, 3);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", int'(req_ready), 4'b0100);
    wait_valid("single", n);
    chk("single_latency", n, 2);
    chk("single_id", int'(rsp_id), 2);
    chk("single_data", int'(rsp_data), 9);
    drain();

    // Pointer now at 3: requesters 1 and 3 compete across the wrap.
    act_ids.delete(); act_data.delete();
    set_op(1, 2, 3); set_op(3, 3, 1);
    req_valid = 4'b1010;
    wait_rsps("wrap", 2, 1'b0);
    if (act_ids.size() >= 2) begin
      chk("wrap_first_id", act_ids[0], 3);
      chk("wrap_second_id", act_ids[1], 1);
      chk("wrap_first_data", act_data[0], 3);
      chk("wrap_second_data", act_data[1], 6);
    end
    drain();

    // Requester 0 issues two operand pairs back-to-back.
    act_ids.delete(); act_data.delete();
    set_op(0, 0, 2);
    req_valid = 4'b0001;
    n = 0;
    while (req_valid[0] && n < 10) begin cycle(1'b0, 1'b0); n++; end
    set_op(0, 2, 1);
    req_valid[0] = 1'b1;
    wait_rsps("b2b", 2, 1'b0);
    if (act_ids.size() >= 2) begin
      chk("b2b_id0", act_ids[0], 0);
      chk("b2b_id1", act_ids[1], 0);
      chk("b2b_data0", act_data[0], 0);
      chk("b2b_data1", act_data[1], 2);
    end
    drain();

    // Response back-pressure with another requester left waiting.
    set_op(0, 1, 3); set_op(1, 3, 2);
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    wait_valid("bp", n);
    chk("bp_id", int'(rsp_id), 1);
    chk("bp_data", int'(rsp_data), 6);
    cid = int'(rsp_id); cdat = int'(rsp_data);
    repeat (5) begin
      cycle(1'b0, 1'b0);
      chk("bp_hold_valid", int'(rsp_valid), 1);
      chk("bp_hold_id", int'(rsp_id), cid);
      chk("bp_hold_data", int'(rsp_data), cdat);
      chk("bp_hold_ready", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    cycle(1'b0, 1'b0);
    chk("bp_resume_ready", int'(req_ready), 4'b0001);
    drain();

    // Random traffic: withdrawals, operand changes and random back-pressure.
    repeat (600) cycle(1'b0, 1'b1);
    drain();

    // Reset while a response is being held.
    set_op(3, 3, 2);
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    wait_valid("midrst", n);
    chk_en = 1'b0;
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    check_outputs_zero("midrst");
    req_valid = '0;
    sb.delete();
    m_busy = 1'b0; m_ptr = 0; m_last_a = 0; m_last_b = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;
    act_ids.delete(); act_data.delete();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, $urandom_range(0, 3), $urandom_range(0, 3));
    req_valid = '1;
    rsp_ready = 1'b1;
    wait_rsps("postrst", 1, 1'b0);
    if (act_ids.size() >= 1) chk("postrst_first_id", act_ids[0], 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
